// File: rtl/cnc_pkg.sv
// Shared types and constants for the CNC streaming reduction engine.
package cnc_pkg;

    localparam int CNC_DATA_W  = 8;
    localparam int CNC_OUT_W   = 17;
    localparam int CNC_MAX_LEN = 512;

    localparam logic [CNC_OUT_W-1:0] CNC_SAT = '1;

    typedef enum logic [1:0] {
        CNC_SUM = 2'b00,
        CNC_MAX = 2'b01,
        CNC_MIN = 2'b10,
        CNC_MAC = 2'b11
    } cnc_mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } cnc_state_e;

endpackage

// File: rtl/cnc_if.sv
// CNC stimulus interface: framed samples in, one strobed result per frame out.
interface cnc_if
    import cnc_pkg::*;
#(
    parameter int DATA_W = CNC_DATA_W,
    parameter int OUT_W  = CNC_OUT_W
);
    logic              in_en;
    logic [1:0]        mode;
    logic [DATA_W-1:0] in_data;
    logic              out_en;
    logic [OUT_W-1:0]  out_data;

    modport master (output in_en, output mode, output in_data,
                    input  out_en, input  out_data);

    modport slave  (input  in_en, input  mode, input  in_data,
                    output out_en, output out_data);
endinterface

// File: rtl/cnc_alu.sv
// Combinational fold step: combines one sample into the running frame state.
module cnc_alu
    import cnc_pkg::*;
#(
    parameter int DATA_W = CNC_DATA_W,
    parameter int OUT_W  = CNC_OUT_W
) (
    input  cnc_mode_e         mode_i,
    input  logic [OUT_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] held_i,
    input  logic              pair_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              first_i,
    output logic [OUT_W-1:0]  acc_o,
    output logic [DATA_W-1:0] held_o,
    output logic              pair_o
);
    localparam logic [OUT_W-1:0] SAT = {OUT_W{1'b1}};

    logic [OUT_W-1:0]    sample_ext;
    logic [2*DATA_W-1:0] product;
    logic [OUT_W:0]      sum_wide;
    logic [OUT_W:0]      mac_wide;

    assign sample_ext = OUT_W'(sample_i);
    assign product    = (2*DATA_W)'(held_i) * (2*DATA_W)'(sample_i);
    // One extra carry bit detects overflow; once saturated the sum stays pinned.
    assign sum_wide   = {1'b0, acc_i} + (OUT_W+1)'(sample_i);
    assign mac_wide   = {1'b0, acc_i} + (OUT_W+1)'(product);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        acc_o  = acc_i;
        held_o = held_i;
        pair_o = pair_i;
        if (first_i) begin
            if (mode_i == CNC_MAC) begin
                acc_o  = '0;
                held_o = sample_i;
                pair_o = 1'b1;
            end else begin
                acc_o  = sample_ext;
                held_o = '0;
                pair_o = 1'b0;
            end
        end else begin
            unique case (mode_i)
                CNC_SUM: acc_o = sum_wide[OUT_W] ? SAT : sum_wide[OUT_W-1:0];
                CNC_MAX: acc_o = (sample_ext > acc_i) ? sample_ext : acc_i;
                CNC_MIN: acc_o = (sample_ext < acc_i) ? sample_ext : acc_i;
                CNC_MAC: begin
                    if (pair_i) begin
                        acc_o  = mac_wide[OUT_W] ? SAT : mac_wide[OUT_W-1:0];
                        pair_o = 1'b0;
                    end else begin
                        held_o = sample_i;
                        pair_o = 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/cnc_engine.sv
// Frame FSM, sample counter and registered result strobe for the CNC engine.
module cnc_engine
    import cnc_pkg::*;
#(
    parameter int DATA_W  = CNC_DATA_W,
    parameter int OUT_W   = CNC_OUT_W,
    parameter int MAX_LEN = CNC_MAX_LEN
) (
    input  logic  clk,
    input  logic  reset,
    cnc_if.slave  cnc
);
    localparam int             CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

    cnc_state_e        state_q, state_d;
    cnc_mode_e         mode_q, mode_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic              pair_q, pair_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_en_q, out_en_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;

    logic              close, start, fold;
    cnc_mode_e         alu_mode;
    logic [OUT_W-1:0]  alu_acc;
    logic [DATA_W-1:0] alu_held;
    logic              alu_pair;

    // A close and a new start may share one edge: forced close with in_en still high.
    assign close    = (state_q == ST_ACCUM) && (!cnc.in_en || count_q == CNT_MAX);
    assign start    = cnc.in_en && ((state_q == ST_IDLE) || close);
    assign fold     = (state_q == ST_ACCUM) && cnc.in_en && !close;
    assign alu_mode = start ? cnc_mode_e'(cnc.mode) : mode_q;

    cnc_alu #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_alu (
        .mode_i   (alu_mode),
        .acc_i    (acc_q),
        .held_i   (held_q),
        .pair_i   (pair_q),
        .sample_i (cnc.in_data),
        .first_i  (start),
        .acc_o    (alu_acc),
        .held_o   (alu_held),
        .pair_o   (alu_pair)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        held_d     = held_q;
        pair_d     = pair_q;
        count_d    = count_q;
        out_en_d   = 1'b0;
        out_data_d = '0;
        if (close) begin
            out_en_d   = 1'b1;
            out_data_d = acc_q;
            state_d    = ST_IDLE;
        end
        if (start) begin
            state_d = ST_ACCUM;
            mode_d  = cnc_mode_e'(cnc.mode);
            acc_d   = alu_acc;
            held_d  = alu_held;
            pair_d  = alu_pair;
            count_d = CNT_W'(1);
        end else if (fold) begin
            acc_d   = alu_acc;
            held_d  = alu_held;
            pair_d  = alu_pair;
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= CNC_SUM;
            acc_q      <= '0;
            held_q     <= '0;
            pair_q     <= 1'b0;
            count_q    <= '0;
            out_en_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            held_q     <= held_d;
            pair_q     <= pair_d;
            count_q    <= count_d;
            out_en_q   <= out_en_d;
            out_data_q <= out_data_d;
        end
    end

    assign cnc.out_en   = out_en_q;
    assign cnc.out_data = out_data_q;
endmodule

// File: tb/tb_cnc_engine.sv
// Scoreboard bench for cnc_engine: directed frames plus randomized bursts.
module tb_cnc_engine;
    import cnc_pkg::*;

    localparam int MAX_LEN = CNC_MAX_LEN;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    cnc_if bus ();

    cnc_engine dut (
        .clk   (clk),
        .reset (reset),
        .cnc   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Frame result straight from the arithmetic definition of each mode.
    function automatic int ref_result(input logic [1:0] m, input int s[$], input int lo, input int hi);
        longint acc;
        case (m)
            2'b00: begin
                acc = 0;
                for (int i = lo; i <= hi; i++) acc += s[i];
            end
            2'b01: begin
                acc = 0;
                for (int i = lo; i <= hi; i++) if (s[i] > acc) acc = s[i];
            end
            2'b10: begin
                acc = (1 << CNC_DATA_W) - 1;
                for (int i = lo; i <= hi; i++) if (s[i] < acc) acc = s[i];
            end
            default: begin
                acc = 0;
                for (int i = lo; i + 1 <= hi; i += 2) acc += longint'(s[i]) * longint'(s[i+1]);
            end
        endcase
        if (acc > longint'(CNC_SAT)) acc = longint'(CNC_SAT);
        return int'(acc);
    endfunction

    // Drives one contiguous in_en run; frames longer than MAX_LEN split into chunks.
    task automatic drive_burst(input int samples[$], input logic [1:0] modes[$], input int gap);
        int c0;
        int n;
        n = samples.size();
        @(posedge clk); #1;
        c0 = cycle;
        for (int lo = 0; lo < n; lo += MAX_LEN) begin
            int hi;
            exp_t e;
            hi = (lo + MAX_LEN - 1 < n - 1) ? lo + MAX_LEN - 1 : n - 1;
            e.data = ref_result(modes[lo], samples, lo, hi);
            e.cyc  = c0 + 2 + hi;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            bus.in_en   = 1'b1;
            bus.mode    = modes[i];
            bus.in_data = samples[i][7:0];
        end
        @(posedge clk); #1;
        bus.in_en   = 1'b0;
        bus.in_data = 8'($urandom);
        bus.mode    = 2'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    task automatic burst_const(input logic [1:0] m, input int samples[$], input int gap);
        logic [1:0] modes[$];
        for (int i = 0; i < samples.size(); i++) modes.push_back(m);
        drive_burst(samples, modes, gap);
    endtask

    task automatic burst_fill(input logic [1:0] m, input int n, input int val, input int gap);
        int s[$];
        for (int i = 0; i < n; i++) s.push_back(val);
        burst_const(m, s, gap);
    endtask

    // Monitor: every strobe pops one expectation; outside strobes data must read 0.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_en) begin
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", 32'(bus.out_en), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", 32'(bus.out_data), 32'(e.data));
                    check("latency", 32'(cycle), 32'(e.cyc));
                end
            end else begin
                check("idle_data", 32'(bus.out_data), 32'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s[$];
        logic [1:0] ms[$];

        bus.in_en   = 1'b0;
        bus.mode    = 2'b00;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_en", 32'(bus.out_en), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);

        burst_const(2'b00, '{10, 20, 30}, 2);
        burst_const(2'b01, '{7, 200, 3}, 0);
        burst_const(2'b10, '{7, 200, 3}, 1);
        burst_const(2'b11, '{3, 4, 5, 6, 9}, 0);
        burst_const(2'b11, '{77}, 1);
        burst_fill(2'b00, 513, 255, 2);
        burst_fill(2'b11, 512, 255, 1);
        burst_fill(2'b01, 1024, 9, 1);

        s  = '{1, 2, 3};
        ms = '{2'b00, 2'b01, 2'b01};
        drive_burst(s, ms, 1);

        // Partial frame killed by reset: nothing is queued for it.
        @(posedge clk); #1;
        bus.in_en = 1'b1; bus.mode = 2'b00; bus.in_data = 8'd40;
        @(posedge clk); #1;
        bus.in_data = 8'd50;
        @(posedge clk); #1;
        bus.in_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_out_en", 32'(bus.out_en), 32'd0);
        check("post_reset_out_data", 32'(bus.out_data), 32'd0);
        burst_const(2'b00, '{5, 5}, 1);

        for (int b = 0; b < 48; b++) begin
            int n;
            s.delete();
            ms.delete();
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(500, 540) : $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                s.push_back(($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
                ms.push_back(2'($urandom));
            end
            drive_burst(s, ms, $urandom_range(0, 3));
        end

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
